// File: rtl/password_controller_if.sv
// Store-side bus of the password controller: combinational read port plus a single write port.
interface password_controller_if #(
   parameter int AW = 2,
   parameter int DW = 4
);
   logic [AW-1:0] store_addr;
   logic          store_write;
   logic [DW-1:0] store_wdata;
   logic [DW-1:0] store_rdata;

   modport master (output store_addr, store_write, store_wdata, input store_rdata);
   modport slave  (input store_addr, store_write, store_wdata, output store_rdata);
endinterface

// File: rtl/password_controller.sv
// Serial BCD password entry: check against / set into a DIGITS-deep store, count failures, latch alarm.
// Optional PASSWORD_ADMIN_CODE_EN: ADMIN_CODE also unlocks, and is the only way out of ALARM besides RST_N.
module password_controller #(
   parameter int                  DIGITS        = 4,
   parameter int                  MAX_FAILS     = 3,
   parameter int                  RESULT_CYCLES = 8,
   parameter logic [4*DIGITS-1:0] ADMIN_CODE    = 16'h9527
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  digit_valid,
   input  logic [3:0]            digit,
   input  logic                  set_mode,
   input  logic                  abort,
   password_controller_if.master store,
   output logic                  unlock,
   output logic                  fail,
   output logic                  alarm,
   output logic                  busy
);
   localparam int            AW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int            HW   = $clog2(RESULT_CYCLES + 1);
   localparam logic [AW-1:0] LAST = AW'(DIGITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_ENTER, S_COMMIT, S_RESULT, S_ALARM} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] idx;
   logic [AW-1:0] dig_idx;
   logic          mode_set, mismatch, alarm_entry, result_ok, pwd_valid, armed;
   logic [2:0]    fail_cnt;
   logic [HW-1:0] hold;
   logic [3:0]    shadow [DIGITS];
   logic          start, start_set, take, done, cur_mis, check_ok;

`ifdef PASSWORD_ADMIN_CODE_EN
   logic admin_mis, cur_admin_mis;
`else
   logic unused_admin;
   assign unused_admin = ^ADMIN_CODE;
`endif

   // A digit outside ENTER is always index 0 of a fresh entry.
   always_comb begin
      start     = (state != S_ENTER);
      dig_idx   = start ? '0 : idx;
      start_set = !pwd_valid || (set_mode && armed);
      cur_mis   = (start ? 1'b0 : mismatch) | (digit != store.store_rdata);
`ifdef PASSWORD_ADMIN_CODE_EN
      cur_admin_mis = (start ? 1'b0 : admin_mis) | (digit != ADMIN_CODE[{dig_idx, 2'b00} +: 4]);
      check_ok      = alarm_entry ? !cur_admin_mis : (!cur_mis || !cur_admin_mis);
`else
      check_ok      = !cur_mis;
`endif
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx          = state;
      take              = 1'b0;
      done              = 1'b0;
      store.store_addr  = '0;
      store.store_write = 1'b0;
      store.store_wdata = '0;
      case (state)
         S_IDLE: begin
            if (digit_valid) begin
               take     = 1'b1;
               state_nx = S_ENTER;
            end
         end
         S_ENTER: begin
            store.store_addr = idx;
            if (abort) begin
               state_nx = alarm_entry ? S_ALARM : S_IDLE;
            end else if (digit_valid) begin
               take = 1'b1;
               if (idx == LAST) begin
                  done = 1'b1;
                  if (mode_set)                    state_nx = S_COMMIT;
                  else if (alarm_entry && !check_ok) state_nx = S_ALARM;
                  else                             state_nx = S_RESULT;
               end
            end
         end
         S_COMMIT: begin
            store.store_addr  = idx;
            store.store_write = 1'b1;
            store.store_wdata = shadow[idx];
            if (idx == LAST) state_nx = S_RESULT;
         end
         S_RESULT: begin
            if (!result_ok && fail_cnt == 3'(MAX_FAILS)) state_nx = S_ALARM;
            else if (hold == HW'(RESULT_CYCLES - 1))     state_nx = S_IDLE;
         end
         S_ALARM: begin
`ifdef PASSWORD_ADMIN_CODE_EN
            if (digit_valid) begin
               take     = 1'b1;
               state_nx = S_ENTER;
            end
`endif
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         idx         <= '0;
         mode_set    <= 1'b0;
         mismatch    <= 1'b0;
         alarm_entry <= 1'b0;
         result_ok   <= 1'b0;
         pwd_valid   <= 1'b0;
         armed       <= 1'b0;
         fail_cnt    <= '0;
         hold        <= '0;
`ifdef PASSWORD_ADMIN_CODE_EN
         admin_mis   <= 1'b0;
`endif
      end else begin
         if (take) begin
            mismatch <= cur_mis;
            idx      <= idx + 1'b1;
`ifdef PASSWORD_ADMIN_CODE_EN
            admin_mis <= cur_admin_mis;
`endif
            if (start) begin
               idx         <= AW'(1);
               mode_set    <= (state == S_IDLE) && start_set;
               alarm_entry <= (state == S_ALARM);
               if (state == S_IDLE) armed <= 1'b0;
            end
         end
         if (state == S_ENTER && abort) begin
            idx         <= '0;
            alarm_entry <= 1'b0;
         end
         if (done) begin
            idx         <= '0;
            hold        <= '0;
            alarm_entry <= 1'b0;
            if (!mode_set) begin
               result_ok <= check_ok;
               if (check_ok) begin
                  fail_cnt <= '0;
                  armed    <= 1'b1;
               end else if (!alarm_entry) begin
                  fail_cnt <= fail_cnt + 3'd1;
               end
            end
         end
         if (state == S_COMMIT) begin
            idx <= idx + 1'b1;
            if (idx == LAST) begin
               idx       <= '0;
               pwd_valid <= 1'b1;
               result_ok <= 1'b1;
               fail_cnt  <= '0;
               hold      <= '0;
            end
         end
         if (state == S_RESULT) hold <= hold + 1'b1;
      end
   end

   // Shadow only matters after a completed set entry, which rewrites every slot.
   always_ff @(posedge CLK) begin
      if (take) shadow[dig_idx] <= digit;
   end

   assign unlock = (state == S_RESULT) && result_ok;
   assign fail   = (state == S_RESULT) && !result_ok;
   assign alarm  = (state == S_ALARM) || alarm_entry;
   assign busy   = (state == S_ENTER) || (state == S_COMMIT);
endmodule

// File: tb/tb_password_controller.sv
// Randomised entries against a digit-sequence model of the password rules, plus the lock store model.
module tb_password_controller;
   localparam int          MAX_FAILS = 3;
   localparam logic [15:0] ADMIN     = 16'h9527;
`ifdef PASSWORD_ADMIN_CODE_EN
   localparam bit ADMIN_EN = 1'b1;
`else
   localparam bit ADMIN_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       digit_valid = 1'b0;
   logic [3:0] digit = 4'd0;
   logic       set_mode = 1'b0;
   logic       abort = 1'b0;
   logic       unlock, fail, alarm, busy;
   logic [3:0] mem [4];

   int total = 0;
   int bad   = 0;

   // reference model state
   bit          m_valid = 1'b0;
   bit          m_armed = 1'b0;
   bit          m_alarm = 1'b0;
   int          m_fails = 0;
   logic [15:0] m_pwd   = 16'h0;

   password_controller_if sif ();

   password_controller dut (
      .CLK         (clk),
      .RST_N       (rst_n),
      .digit_valid (digit_valid),
      .digit       (digit),
      .set_mode    (set_mode),
      .abort       (abort),
      .store       (sif),
      .unlock      (unlock),
      .fail        (fail),
      .alarm       (alarm),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   assign sif.store_rdata = mem[sif.store_addr];
   always @(posedge clk) if (sif.store_write) mem[sif.store_addr] <= sif.store_wdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] pk(input int a, input int b, input int c, input int d);
      return {4'(d), 4'(c), 4'(b), 4'(a)};
   endfunction

   function automatic logic [15:0] rnd_code();
      return pk($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
   endfunction

   task automatic reset_dut();
      rst_n = 1'b0; digit_valid = 1'b0; abort = 1'b0; set_mode = 1'b0; digit = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_unlock", unlock, 0);
      check("rst_fail", fail, 0);
      check("rst_alarm", alarm, 0);
      check("rst_busy", busy, 0);
      check("rst_write", sif.store_write, 0);
      rst_n = 1'b1;
      m_valid = 1'b0; m_armed = 1'b0; m_alarm = 1'b0; m_fails = 0;
   endtask

   // ab < 0: full entry; ab in 1..3: abort strobed together with that digit
   task automatic entry(input logic [15:0] dg, input bit sm, input int ab);
      bit e_set, e_unlock, e_fail, e_fail_dc, e_busy1, inject;
      int n_unl, n_fail, n_wr, first_unl;
      e_set = 0; e_unlock = 0; e_fail = 0; e_fail_dc = 0; inject = 0;
      n_unl = 0; n_fail = 0; n_wr = 0; first_unl = 0;

      if (ab >= 0) begin
         e_busy1 = !m_alarm || ADMIN_EN;
         if (!m_alarm) m_armed = 0;
      end else if (m_alarm) begin
         e_busy1 = ADMIN_EN;
         if (ADMIN_EN && dg == ADMIN) begin
            m_alarm = 0; m_fails = 0; m_armed = 1; e_unlock = 1;
         end
      end else begin
         e_busy1 = 1; inject = 1;
         e_set   = !m_valid || (sm && m_armed);
         m_armed = 0;
         if (e_set) begin
            m_pwd = dg; m_valid = 1; m_fails = 0; e_unlock = 1;
         end else if (dg == m_pwd || (ADMIN_EN && dg == ADMIN)) begin
            e_unlock = 1; m_fails = 0; m_armed = 1;
         end else begin
            m_fails++;
            if (m_fails == MAX_FAILS) begin
               m_alarm = 1; e_fail_dc = 1; inject = 0;
            end else begin
               e_fail = 1;
            end
         end
      end

      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         digit_valid = 1'b1;
         digit       = 4'(dg >> (4 * i));
         set_mode    = (i == 0) ? sm : 1'($urandom_range(0, 1));
         abort       = (i == ab);
         @(posedge clk);
         #1;
         digit_valid = 1'b0; abort = 1'b0; set_mode = 1'b0;
         if (i == 0) check("busy_start", busy, e_busy1);
         if (i == ab) break;
      end

      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (unlock) begin
            if (n_unl == 0) first_unl = c;
            n_unl++;
         end
         if (fail) n_fail++;
         if (sif.store_write) begin
            if (e_set && n_wr < 4) begin
               check("wr_addr", sif.store_addr, n_wr);
               check("wr_data", sif.store_wdata, 4'(dg >> (4 * n_wr)));
            end
            n_wr++;
         end
         if (ab >= 0 && c == 1) check("abort_busy", busy, 0);
         if (inject && c == 3) begin
            digit_valid = 1'b1; abort = 1'b1; digit = 4'($urandom_range(0, 9));
         end
         if (c == 4) begin
            digit_valid = 1'b0; abort = 1'b0;
         end
      end

      check("unlock_cycles", n_unl, e_unlock ? 8 : 0);
      if (e_unlock) check("unlock_latency", first_unl, e_set ? 5 : 1);
      if (!e_fail_dc) check("fail_cycles", n_fail, e_fail ? 8 : 0);
      check("write_count", n_wr, e_set ? 4 : 0);
      check("alarm_end", alarm, m_alarm);
      check("busy_end", busy, 0);
      check("unlock_end", unlock, 0);
      if (e_set) check("store_image", {mem[3], mem[2], mem[1], mem[0]}, dg);
   endtask

   initial begin
      reset_dut();
      entry(pk(1, 2, 3, 4), 0, -1);
      entry(pk(1, 2, 3, 4), 0, -1);
      entry(pk(1, 2, 3, 5), 0, -1);
      entry(pk(1, 2, 3, 4), 0, -1);
      repeat (3) entry(pk(0, 0, 0, 0), 0, -1);
      entry(pk(1, 2, 3, 4), 0, -1);
`ifdef PASSWORD_ADMIN_CODE_EN
      entry(pk(7, 2, 5, 9), 0, -1);
      entry(pk(0, 0, 0, 0), 0, -1);
      entry(pk(1, 2, 3, 4), 0, -1);
`endif
      reset_dut();
      entry(pk(1, 2, 3, 4), 1, -1);
      entry(pk(1, 2, 3, 4), 0, -1);
      entry(pk(5, 6, 7, 8), 1, -1);
      entry(pk(5, 6, 7, 8), 0, -1);
      entry(pk(0, 0, 0, 0), 0, -1);
      entry(pk(9, 9, 9, 9), 1, -1);
      entry(pk(5, 6, 7, 8), 0, -1);
      entry(pk(1, 2, 3, 4), 0, 2);
      entry(pk(5, 6, 7, 8), 0, -1);
      entry(pk(0, 0, 0, 0), 0, -1);
      entry(pk(1, 2, 3, 4), 0, 2);
      entry(pk(0, 0, 0, 0), 0, -1);
      entry(pk(0, 0, 0, 0), 0, -1);
      reset_dut();

      for (int n = 0; n < 40; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (m_alarm && r >= 7) reset_dut();
         else if (r <= 3) entry(m_pwd, 1'($urandom_range(0, 1)), -1);
         else if (r <= 6) entry(rnd_code(), 1'($urandom_range(0, 1)), -1);
         else if (r == 7) entry(rnd_code(), 1'b1, -1);
         else if (r == 8) entry(rnd_code(), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
         else entry(m_pwd, 1'b1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
